instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_format_pkg.sv | 37 +++
 rtl/instruction_field_packer.sv | 52 +++++
 rtl/instruction_encoder.sv | 114 +++++++++++
 tb/tb_instruction_encoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_format_pkg.sv
// Shared instruction format definitions used by both the encoder and the decoder.
// Holds format codes, the special opcode values and the bit positions of every field.
package instruction_format_pkg;

  typedef enum logic [1:0] {
    FMT_REG  = 2'd0,
    FMT_IMM  = 2'd1,
    FMT_JUMP = 2'd2,
    FMT_BAD  = 2'd3
  } format_e;

  localparam logic [5:0] OP_NONE  = 6'b000000;
  localparam logic [5:0] OP_IMM_A = 6'b100010;
  localparam logic [5:0] OP_IMM_B = 6'b100011;

  localparam int WORD_W      = 32;
  localparam int REG_W       = 5;
  localparam int OPC_W       = 17;
  localparam int FUNC_W      = 6;
  localparam int IMM_W       = 26;
  localparam int SHORT_IMM_W = 16;

  localparam int RSRC1_LSB    = 27;
  localparam int RSRC2_LSB    = 22;
  localparam int RDST_REG_LSB = 17;
  localparam int RDST_IMM_LSB = 22;
  localparam int IMM_LSB      = 6;
  localparam int OPC_LSB      = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_EMIT,
    ST_DONE
  } enc_state_e;

endpackage

// File: rtl/instruction_field_packer.sv
// Combinational packer: builds the 32-bit instruction word for the selected format
// and reports whether that format/opcode/immediate combination is encodable.
module instruction_field_packer
  import instruction_format_pkg::*;
(
  input  logic [1:0]        fmt,
  input  logic [REG_W-1:0]  rsrc1,
  input  logic [REG_W-1:0]  rsrc2,
  input  logic [REG_W-1:0]  rdst,
  input  logic [OPC_W-1:0]  op_code,
  input  logic [IMM_W-1:0]  immediate,
  output logic [WORD_W-1:0] word,
  output logic              legal
);

  logic [FUNC_W-1:0] func;

  assign func = op_code[FUNC_W-1:0];

  // Place the fields used by the selected format; all other fields are ignored.
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (format_e'(fmt))
      FMT_REG: begin
        word[RSRC1_LSB +: REG_W]    = rsrc1;
        word[RSRC2_LSB +: REG_W]    = rsrc2;
        word[RDST_REG_LSB +: REG_W] = rdst;
        word[OPC_LSB +: OPC_W]      = op_code;
        legal = (func == OP_NONE);
      end
      FMT_IMM: begin
        word[RSRC1_LSB +: REG_W]      = rsrc1;
        word[RDST_IMM_LSB +: REG_W]   = rdst;
        word[IMM_LSB +: SHORT_IMM_W]  = immediate[SHORT_IMM_W-1:0];
        word[OPC_LSB +: FUNC_W]       = func;
        legal = ((func == OP_IMM_A) || (func == OP_IMM_B)) &&
                (immediate[IMM_W-1:SHORT_IMM_W] == '0);
      end
      FMT_JUMP: begin
        word[IMM_LSB +: IMM_W]  = immediate;
        word[OPC_LSB +: FUNC_W] = func;
        legal = !((func == OP_NONE) || (func == OP_IMM_A) || (func == OP_IMM_B));
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Burst instruction encoder: accepts instruction fields one at a time, packs them,
// and writes each legal word to consecutive memory addresses with a ready handshake.
module instruction_encoder
  import instruction_format_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic [7:0]          Base_Address,
  input  logic [7:0]          Word_Count,
  input  logic                In_Valid,
  output logic                In_Ready,
  input  logic [1:0]          In_Format,
  input  logic [REG_W-1:0]    In_Rsrc1,
  input  logic [REG_W-1:0]    In_Rsrc2,
  input  logic [REG_W-1:0]    In_Rdst,
  input  logic [OPC_W-1:0]    In_OP_Code,
  input  logic [IMM_W-1:0]    In_Immediate,
  output logic                Mem_Write_Enable,
  output logic [7:0]          Mem_Address,
  output logic [WORD_W-1:0]   Mem_Data,
  input  logic                Mem_Ready,
  output logic                Busy,
  output logic                Done,
  output logic                ENFR_FLAG
);

  enc_state_e        state;
  logic [7:0]        remaining;
  logic [WORD_W-1:0] packed_word;
  logic              packed_legal;

  instruction_field_packer u_packer (
    .fmt       (In_Format),
    .rsrc1     (In_Rsrc1),
    .rsrc2     (In_Rsrc2),
    .rdst      (In_Rdst),
    .op_code   (In_OP_Code),
    .immediate (In_Immediate),
    .word      (packed_word),
    .legal     (packed_legal)
  );

  // Burst control FSM; every output is a register updated alongside the state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state            <= ST_IDLE;
      remaining        <= 8'd0;
      In_Ready         <= 1'b0;
      Mem_Write_Enable <= 1'b0;
      Mem_Address      <= 8'd0;
      Mem_Data         <= '0;
      Busy             <= 1'b0;
      Done             <= 1'b0;
      ENFR_FLAG        <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            ENFR_FLAG   <= 1'b0;
            Mem_Address <= Base_Address;
            remaining   <= Word_Count;
            if (Word_Count != 8'd0) begin
              state    <= ST_ACCEPT;
              In_Ready <= 1'b1;
              Busy     <= 1'b1;
            end else begin
              state <= ST_DONE;
              Done  <= 1'b1;
            end
          end
        end
        ST_ACCEPT: begin
          if (In_Valid) begin
            if (packed_legal) begin
              Mem_Data         <= packed_word;
              Mem_Write_Enable <= 1'b1;
              In_Ready         <= 1'b0;
              state            <= ST_EMIT;
            end else begin
              ENFR_FLAG <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (Mem_Ready) begin
            Mem_Write_Enable <= 1'b0;
            Mem_Address      <= Mem_Address + 8'd1;
            remaining        <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state <= ST_DONE;
              Done  <= 1'b1;
              Busy  <= 1'b0;
            end else begin
              state    <= ST_ACCEPT;
              In_Ready <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state            <= ST_IDLE;
          In_Ready         <= 1'b0;
          Mem_Write_Enable <= 1'b0;
          Busy             <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: a table of instruction vectors run
// through one burst, then hand-written sequences for stalls, wrap, empty bursts and reset.
module tb_instruction_encoder;

  logic        Clock;
  logic        Reset_n;
  logic        Start;
  logic [7:0]  Base_Address;
  logic [7:0]  Word_Count;
  logic        In_Valid;
  logic        In_Ready;
  logic [1:0]  In_Format;
  logic [4:0]  In_Rsrc1;
  logic [4:0]  In_Rsrc2;
  logic [4:0]  In_Rdst;
  logic [16:0] In_OP_Code;
  logic [25:0] In_Immediate;
  logic        Mem_Write_Enable;
  logic [7:0]  Mem_Address;
  logic [31:0] Mem_Data;
  logic        Mem_Ready;
  logic        Busy;
  logic        Done;
  logic        ENFR_FLAG;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  fmt;
    logic [4:0]  rsrc1;
    logic [4:0]  rsrc2;
    logic [4:0]  rdst;
    logic [16:0] op;
    logic [25:0] imm;
    logic        legal;
    logic [31:0] data;
  } vec_t;

  localparam int NUM_VEC = 11;
  vec_t vectors [NUM_VEC];

  instruction_encoder dut (
    .Clock            (Clock),
    .Reset_n          (Reset_n),
    .Start            (Start),
    .Base_Address     (Base_Address),
    .Word_Count       (Word_Count),
    .In_Valid         (In_Valid),
    .In_Ready         (In_Ready),
    .In_Format        (In_Format),
    .In_Rsrc1         (In_Rsrc1),
    .In_Rsrc2         (In_Rsrc2),
    .In_Rdst          (In_Rdst),
    .In_OP_Code       (In_OP_Code),
    .In_Immediate     (In_Immediate),
    .Mem_Write_Enable (Mem_Write_Enable),
    .Mem_Address      (Mem_Address),
    .Mem_Data         (Mem_Data),
    .Mem_Ready        (Mem_Ready),
    .Busy             (Busy),
    .Done             (Done),
    .ENFR_FLAG        (ENFR_FLAG)
  );

  // Free-running 10-unit clock.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    In_Format    = v.fmt;
    In_Rsrc1     = v.rsrc1;
    In_Rsrc2     = v.rsrc2;
    In_Rdst      = v.rdst;
    In_OP_Code   = v.op;
    In_Immediate = v.imm;
  endtask

  task automatic startBurst(input logic [7:0] base, input logic [7:0] count);
    Base_Address = base;
    Word_Count   = count;
    Start        = 1'b1;
    step();
    Start = 1'b0;
  endtask

  initial begin
    vec_t       v;
    int         legal_count;
    logic [7:0] exp_addr;
    logic       exp_enfr;

    vectors[0]  = '{2'd0, 5'd1,  5'd2, 5'd3,  17'h00000, 26'h0000000, 1'b1, 32'h08860000};
    vectors[1]  = '{2'd1, 5'd4,  5'd9, 5'd5,  17'h1FFE2, 26'h000FFFF, 1'b1, 32'h217FFFE2};
    vectors[2]  = '{2'd2, 5'd0,  5'd0, 5'd0,  17'h00022, 26'h0000001, 1'b0, 32'h00000000};
    vectors[3]  = '{2'd2, 5'd7,  5'd7, 5'd7,  17'h00001, 26'h0000001, 1'b1, 32'h00000041};
    vectors[4]  = '{2'd0, 5'd31, 5'd0, 5'd31, 17'h00040, 26'h0000000, 1'b1, 32'hF83E0040};
    vectors[5]  = '{2'd0, 5'd0,  5'd0, 5'd0,  17'h00001, 26'h0000000, 1'b0, 32'h00000000};
    vectors[6]  = '{2'd1, 5'd0,  5'd0, 5'd1,  17'h00023, 26'h0010000, 1'b0, 32'h00000000};
    vectors[7]  = '{2'd1, 5'd0,  5'd0, 5'd1,  17'h00023, 26'h0001234, 1'b1, 32'h00448D23};
    vectors[8]  = '{2'd3, 5'd1,  5'd1, 5'd1,  17'h00005, 26'h0000005, 1'b0, 32'h00000000};
    vectors[9]  = '{2'd1, 5'd0,  5'd0, 5'd0,  17'h00001, 26'h0000000, 1'b0, 32'h00000000};
    vectors[10] = '{2'd2, 5'd0,  5'd0, 5'd0,  17'h0003F, 26'h3FFFFFF, 1'b1, 32'hFFFFFFFF};

    Reset_n = 1'b0; Start = 1'b0; Base_Address = 8'd0; Word_Count = 8'd0;
    In_Valid = 1'b0; Mem_Ready = 1'b0;
    In_Format = 2'd0; In_Rsrc1 = 5'd0; In_Rsrc2 = 5'd0; In_Rdst = 5'd0;
    In_OP_Code = 17'd0; In_Immediate = 26'd0;

    // Reset values
    #12;
    checkOutput("reset_in_ready", 32'(In_Ready), 32'd0);
    checkOutput("reset_we", 32'(Mem_Write_Enable), 32'd0);
    checkOutput("reset_addr", 32'(Mem_Address), 32'd0);
    checkOutput("reset_data", Mem_Data, 32'd0);
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_done", 32'(Done), 32'd0);
    checkOutput("reset_enfr", 32'(ENFR_FLAG), 32'd0);
    step();
    Reset_n = 1'b1;
    step();

    // Table-driven burst: one word per legal vector, illegal vectors only raise ENFR_FLAG
    legal_count = 0;
    for (int i = 0; i < NUM_VEC; i++) if (vectors[i].legal) legal_count++;
    startBurst(8'h10, 8'(legal_count));
    checkOutput("burst_in_ready", 32'(In_Ready), 32'd1);
    checkOutput("burst_busy", 32'(Busy), 32'd1);
    exp_addr = 8'h10;
    exp_enfr = 1'b0;
    for (int i = 0; i < NUM_VEC; i++) begin
      v = vectors[i];
      applyStimulus(v);
      In_Valid = 1'b1;
      step();
      In_Valid = 1'b0;
      if (v.legal) begin
        checkOutput($sformatf("vec%0d_we", i), 32'(Mem_Write_Enable), 32'd1);
        checkOutput($sformatf("vec%0d_data", i), Mem_Data, v.data);
        checkOutput($sformatf("vec%0d_addr", i), 32'(Mem_Address), 32'(exp_addr));
        checkOutput($sformatf("vec%0d_in_ready", i), 32'(In_Ready), 32'd0);
        Mem_Ready = 1'b1;
        step();
        Mem_Ready = 1'b0;
        exp_addr = exp_addr + 8'd1;
      end else begin
        exp_enfr = 1'b1;
        checkOutput($sformatf("vec%0d_no_we", i), 32'(Mem_Write_Enable), 32'd0);
        checkOutput($sformatf("vec%0d_in_ready", i), 32'(In_Ready), 32'd1);
        checkOutput($sformatf("vec%0d_busy", i), 32'(Busy), 32'd1);
      end
      checkOutput($sformatf("vec%0d_enfr", i), 32'(ENFR_FLAG), 32'(exp_enfr));
    end
    checkOutput("burst_done", 32'(Done), 32'd1);
    checkOutput("burst_done_busy", 32'(Busy), 32'd0);
    checkOutput("burst_done_we", 32'(Mem_Write_Enable), 32'd0);
    step();
    checkOutput("burst_done_pulse_end", 32'(Done), 32'd0);

    // Address wrap with memory stalls, and Start ignored while busy
    startBurst(8'hFF, 8'd2);
    checkOutput("wrap_enfr_cleared", 32'(ENFR_FLAG), 32'd0);
    checkOutput("wrap_in_ready", 32'(In_Ready), 32'd1);
    applyStimulus('{2'd2, 5'd0, 5'd0, 5'd0, 17'h00001, 26'h0000002, 1'b1, 32'h00000081});
    Start = 1'b1; Word_Count = 8'd0; In_Valid = 1'b1;
    step();
    Start = 1'b0; In_Valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("stall%0d_we", k), 32'(Mem_Write_Enable), 32'd1);
      checkOutput($sformatf("stall%0d_data", k), Mem_Data, 32'h00000081);
      checkOutput($sformatf("stall%0d_addr", k), 32'(Mem_Address), 32'h000000FF);
      step();
    end
    checkOutput("stall_end_we", 32'(Mem_Write_Enable), 32'd1);
    Mem_Ready = 1'b1;
    step();
    Mem_Ready = 1'b0;
    checkOutput("busy_start_no_done", 32'(Done), 32'd0);
    checkOutput("busy_start_in_ready", 32'(In_Ready), 32'd1);
    applyStimulus('{2'd2, 5'd0, 5'd0, 5'd0, 17'h00001, 26'h0000003, 1'b1, 32'h000000C1});
    In_Valid = 1'b1;
    step();
    In_Valid = 1'b0;
    checkOutput("wrap_addr", 32'(Mem_Address), 32'h00000000);
    checkOutput("wrap_data", Mem_Data, 32'h000000C1);
    Mem_Ready = 1'b1;
    step();
    Mem_Ready = 1'b0;
    checkOutput("wrap_done", 32'(Done), 32'd1);
    step();
    checkOutput("wrap_done_pulse_end", 32'(Done), 32'd0);

    // Empty burst goes straight to DONE without writing
    startBurst(8'h40, 8'd0);
    checkOutput("empty_done", 32'(Done), 32'd1);
    checkOutput("empty_busy", 32'(Busy), 32'd0);
    checkOutput("empty_in_ready", 32'(In_Ready), 32'd0);
    checkOutput("empty_we", 32'(Mem_Write_Enable), 32'd0);
    step();
    checkOutput("empty_done_pulse_end", 32'(Done), 32'd0);
    checkOutput("empty_we_after", 32'(Mem_Write_Enable), 32'd0);

    // Reset asserted while a write is pending
    startBurst(8'h20, 8'd1);
    applyStimulus(vectors[0]);
    In_Valid = 1'b1;
    step();
    In_Valid = 1'b0;
    checkOutput("rst_pre_we", 32'(Mem_Write_Enable), 32'd1);
    Reset_n = 1'b0;
    #1;
    checkOutput("rst_async_we", 32'(Mem_Write_Enable), 32'd0);
    checkOutput("rst_async_addr", 32'(Mem_Address), 32'd0);
    checkOutput("rst_async_data", Mem_Data, 32'd0);
    checkOutput("rst_async_busy", 32'(Busy), 32'd0);
    checkOutput("rst_async_in_ready", 32'(In_Ready), 32'd0);
    checkOutput("rst_async_done", 32'(Done), 32'd0);
    Mem_Ready = 1'b1;
    step();
    checkOutput("rst_held_we", 32'(Mem_Write_Enable), 32'd0);
    checkOutput("rst_held_done", 32'(Done), 32'd0);
    Reset_n = 1'b1;
    Mem_Ready = 1'b0;
    step();
    checkOutput("rst_release_in_ready", 32'(In_Ready), 32'd0);
    checkOutput("rst_release_busy", 32'(Busy), 32'd0);
    checkOutput("rst_release_done", 32'(Done), 32'd0);
    startBurst(8'h30, 8'd1);
    checkOutput("rst_idle_start_in_ready", 32'(In_Ready), 32'd1);
    checkOutput("rst_idle_start_addr", 32'(Mem_Address), 32'h00000030);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
